// File: rtl/mem_burst_ctrl.sv
// Command-side controller for a 2^AW x DW synchronous-read memory: single-beat writes,
// wrapping read bursts, and a 2-entry output buffer that absorbs the read latency.
module mem_burst_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [AW-1:0] cmd_len,
  input  logic [DW-1:0] cmd_dat,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic [AW-1:0] adr,
  output logic          we,
  output logic [DW-1:0] dat_w,
  input  logic [DW-1:0] dat_r
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_r, state_nxt_s;
  logic [AW-1:0] rd_ptr_r, remaining_r;
  logic          inflight_r, inflight_last_r;
  logic [1:0]    fifo_cnt_r;
  logic [DW-1:0] head_data_r, tail_data_r;
  logic          head_last_r, tail_last_r;
  logic          rd_accept_s, pop_s, room_s, issue_s, issue_last_s;
  logic [2:0]    occupancy_s;

  assign rd_valid = (fifo_cnt_r != 2'd0);
  assign rd_data  = head_data_r;
  assign rd_last  = head_last_r;

  // Handshake and beat-issue decisions; occupancy counts buffered plus inflight beats.
  always_comb begin
    rd_accept_s = cmd_valid & cmd_ready & ~cmd_we;
    pop_s       = rd_valid & rd_ready;
    occupancy_s = {1'b0, fifo_cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    room_s      = (occupancy_s < 3'd2);
    if (state_r == READ) begin
      issue_s      = room_s;
      issue_last_s = (remaining_r == AW'(1));
    end else begin
      issue_s      = rd_accept_s;
      issue_last_s = (cmd_len == AW'(0));
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (rd_accept_s) begin
          state_nxt_s = (cmd_len != AW'(0)) ? READ : DRAIN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ: begin
        if (issue_s && issue_last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = READ;
        end
      end
      DRAIN: begin
        if (!inflight_r && ((fifo_cnt_r == 2'd1 && pop_s) || fifo_cnt_r == 2'd0)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Command handshake and memory port; writes go straight through in IDLE.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    adr       = rd_ptr_r;
    we        = 1'b0;
    dat_w     = cmd_dat;
    case (state_r)
      IDLE: begin
        cmd_ready = rst;
        busy      = 1'b0;
        adr       = cmd_adr;
        we        = cmd_valid & rst & cmd_we;
      end
      READ, DRAIN: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Burst pointer, beat counter and the one-cycle memory latency stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r        <= {AW{1'b0}};
      remaining_r     <= {AW{1'b0}};
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      inflight_r      <= issue_s;
      inflight_last_r <= issue_s & issue_last_s;
      if (rd_accept_s) begin
        rd_ptr_r    <= cmd_adr + AW'(1);
        remaining_r <= cmd_len;
      end else if (state_r == READ && issue_s) begin
        rd_ptr_r    <= rd_ptr_r + AW'(1);
        remaining_r <= remaining_r - AW'(1);
      end else begin
        rd_ptr_r    <= rd_ptr_r;
        remaining_r <= remaining_r;
      end
    end
  end

  // Two-entry output FIFO; head feeds the read stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_cnt_r  <= 2'd0;
      head_data_r <= {DW{1'b0}};
      tail_data_r <= {DW{1'b0}};
      head_last_r <= 1'b0;
      tail_last_r <= 1'b0;
    end else begin
      case ({inflight_r, pop_s})
        2'b10: begin
          if (fifo_cnt_r == 2'd0) begin
            head_data_r <= dat_r;
            head_last_r <= inflight_last_r;
          end else begin
            tail_data_r <= dat_r;
            tail_last_r <= inflight_last_r;
          end
          fifo_cnt_r <= fifo_cnt_r + 2'd1;
        end
        2'b01: begin
          head_data_r <= tail_data_r;
          head_last_r <= tail_last_r;
          fifo_cnt_r  <= fifo_cnt_r - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_r == 2'd1) begin
            head_data_r <= dat_r;
            head_last_r <= inflight_last_r;
          end else begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            tail_data_r <= dat_r;
            tail_last_r <= inflight_last_r;
          end
        end
        default: begin
          fifo_cnt_r <= fifo_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: directed scenarios plus random commands,
// checked against a reference memory image and burst-expansion model.
module tb_mem_burst_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam logic [127:0] INIT = 128'h986e29f40e5b763de8124fa7c123b390;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr, cmd_len;
  logic [DW-1:0] cmd_dat;
  logic          rd_valid, rd_ready, rd_last, busy;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] adr;
  logic          we;
  logic [DW-1:0] dat_w, dat_r;

  logic [7:0] mem [16];
  logic [7:0] ref_mem [16];
  logic       mem_load;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_burst_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_dat(cmd_dat), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .busy(busy), .adr(adr),
    .we(we), .dat_w(dat_w), .dat_r(dat_r)
  );

  // Synchronous-read scratch memory driven by the DUT's port.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= INIT[i*8 +: 8];
    end else begin
      if (we) mem[adr] <= dat_w;
      dat_r <= mem[adr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts and ends just after a rising edge.
  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = a; cmd_dat = d; cmd_len = 4'($urandom);
    @(negedge clk);
    chk("wr_cmd_ready", cmd_ready, 1);
    chk("wr_we", we, 1);
    chk("wr_adr", adr, a);
    chk("wr_dat_w", dat_w, d);
    chk("wr_busy", busy, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    ref_mem[a] = d;
  endtask

  // rmode: 0 = always ready, 1 = 1-0-0-1 pattern, 2 = random ready.
  task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int rmode,
                         input bit hold_wr, input logic [3:0] wa, input logic [7:0] wd,
                         input bit timed);
    logic [7:0] exp_d [$];
    int n, got, c;
    bit done, stall_prev;
    logic [7:0] prev_d;
    logic prev_l;
    n = int'(l) + 1;
    for (int i = 0; i < n; i++) exp_d.push_back(ref_mem[(int'(a) + i) % 16]);
    got = 0; c = 0; done = 1'b0; stall_prev = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = a; cmd_len = l; cmd_dat = 8'($urandom);
    while (!done && c < 200) begin
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      if (c == 0) begin
        chk("rd_cmd_ready", cmd_ready, 1);
        chk("rd_first_adr", adr, a);
        chk("rd_accept_we", we, 0);
      end else if (cmd_ready) begin
        done = 1'b1;
        chk("beats_delivered", got, n);
        chk("idle_rd_valid", rd_valid, 0);
        if (timed) chk("ready_cycle", c, n + 2);
        if (hold_wr) begin
          chk("held_we", we, 1);
          chk("held_adr", adr, wa);
          chk("held_dat_w", dat_w, wd);
        end
      end else begin
        chk("busy_in_burst", busy, 1);
        if (hold_wr) chk("we_while_busy", we, 0);
      end
      if (stall_prev) begin
        chk("stall_valid", rd_valid, 1);
        chk("stall_data", rd_data, prev_d);
        chk("stall_last", rd_last, prev_l);
      end
      if (rd_valid && rd_ready) begin
        if (got < n) begin
          chk("beat_data", rd_data, exp_d[got]);
          chk("beat_last", rd_last, 32'(got == n - 1));
          if (timed && rmode == 0) chk("beat_cycle", c, got + 2);
        end else begin
          chk("beat_count", got + 1, n);
        end
        got++;
      end
      stall_prev = rd_valid & ~rd_ready;
      prev_d = rd_data;
      prev_l = rd_last;
      @(posedge clk); #1;
      if (c == 0) begin
        if (hold_wr) begin
          cmd_we = 1'b1; cmd_adr = wa; cmd_dat = wd;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (done && hold_wr) begin
        ref_mem[wa] = wd;
        cmd_valid = 1'b0;
      end
      c++;
    end
    chk("read_done", done, 1);
  endtask

  initial begin
    rst = 1'b0; mem_load = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_adr = 4'd0; cmd_len = 4'd0; cmd_dat = 8'h00; rd_ready = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = INIT[i*8 +: 8];
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_busy", busy, 0);
    mem_load = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    @(posedge clk); #1;

    // Power-up contents, wrap, write-then-read, backpressure.
    do_read(4'd0, 4'd2, 0, 1'b0, 4'd0, 8'h00, 1'b1);
    do_read(4'd14, 4'd3, 0, 1'b0, 4'd0, 8'h00, 1'b1);
    do_write(4'd3, 8'h5a);
    do_read(4'd3, 4'd0, 0, 1'b0, 4'd0, 8'h00, 1'b1);
    do_read(4'd4, 4'd15, 1, 1'b0, 4'd0, 8'h00, 1'b0);

    // Write command held while a burst runs.
    do_read(4'd0, 4'd5, 0, 1'b1, 4'd9, 8'hc3, 1'b1);
    do_read(4'd8, 4'd2, 0, 1'b0, 4'd0, 8'h00, 1'b1);

    // Reset during beat 3 of a 16-beat burst.
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 4'd0; cmd_len = 4'd15; rd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_beat3_valid", rd_valid, 1);
    chk("mid_beat3_data", rd_data, ref_mem[2]);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_abort_rd_valid", rd_valid, 0);
      chk("post_abort_cmd_ready", cmd_ready, 1);
    end
    @(posedge clk); #1;

    // Random commands against the reference image.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_write(4'($urandom), 8'($urandom));
      end else begin
        do_read(4'($urandom), 4'($urandom), 2, 1'($urandom_range(0, 1)),
                4'($urandom), 8'($urandom), 1'b0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Command-side controller that sits directly upstream of the 16x8 synchronous-read scratch memory and drives its `adr`/`we`/`dat_w` port while consuming `dat_r`. It accepts single-beat write commands and multi-beat read-burst commands over a valid/ready command interface. Read data returns on a valid/ready stream with `rd_last`, and a 2-entry output buffer absorbs the memory's 1-cycle read latency under backpressure. Bursts wrap from address 15 to 0.

## Interface
- `AW`, default 4: memory address width; depth is 2^AW.
- `DW`, default 8: data width.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_we`  in  1  1 = write one beat, 0 = read burst.
- `cmd_adr`  in  AW  start address.
- `cmd_len`  in  AW  read beats minus 1 (0..15); ignored for writes.
- `cmd_dat`  in  DW  write data.
- `rd_valid`  out  1  read beat present.
- `rd_ready`  in  1  consumer accepts the beat.
- `rd_data`  out  DW  read beat data.
- `rd_last`  out  1  final beat of the burst; qualified by `rd_valid`.
- `busy`  out  1  high whenever the controller is not in IDLE.
- `adr`  out  AW  memory address, to the memory.
- `we`  out  1  memory write enable.
- `dat_w`  out  DW  memory write data.
- `dat_r`  in  DW  memory read data; valid the cycle after `adr` is presented.

## Operation
- States are IDLE, READ and DRAIN.
- `cmd_ready` equals (state == IDLE) and is 0 while `rst` is low.
- Memory port in IDLE:
  - `adr` = `cmd_adr`, `dat_w` = `cmd_dat`.
  - `we` = `cmd_valid & cmd_ready & cmd_we`. A write completes in the accept cycle and the state stays IDLE.
- Memory port in READ/DRAIN:
  - `adr` = `rd_ptr`; `we` = 0 and `dat_w` = `cmd_dat` (don't-care).
- Read accept in IDLE:
  - The first beat is issued in the same cycle (`adr` = `cmd_adr`).
  - `rd_ptr` <= `cmd_adr`+1 mod 2^AW; `remaining` <= `cmd_len`.
  - Next state is READ if `cmd_len` > 0, else DRAIN.
- Issue rule: a beat is issued in a cycle only when `fifo_count + inflight - pop < 2`, where `pop` = `rd_valid & rd_ready`. A stalled cycle still drives `adr` = `rd_ptr` but does not mark a beat inflight.
- In READ, each issued beat does `rd_ptr`++ (wraps 15 to 0) and `remaining`--. The beat issued with `remaining` == 1 moves the state to DRAIN.
- `inflight` is a 1-bit register set on issue; the next cycle it pushes `{dat_r, last}` into the FIFO.
- `last` is 1 for the beat issued when the burst count is exhausted.
- DRAIN moves to IDLE when `inflight` == 0, `fifo_count` == 1 and `pop`, or when `fifo_count` == 0 with nothing inflight.
- FIFO:
  - 2 entries, first-in first-out; `rd_data`/`rd_last`/`rd_valid` come from the head.
  - Data is stable while `rd_valid & !rd_ready`.
  - Push and pop in the same cycle are legal when the FIFO is full. Overflow is impossible by the issue rule.
- Reset (async assert): state IDLE, FIFO empty, `inflight` 0, `rd_ptr` 0, `remaining` 0.
  - Outputs: `rd_valid` 0, `rd_last` 0, `rd_data` 0, `busy` 0.
  - A burst in progress is abandoned and no beats follow release.
- `busy` = (state != IDLE).

## Timing
- Write: accepted in cycle 0; memory updated at the end of cycle 0. A read accepted in cycle 1 returns the new data.
- Read latency: accept in cycle 0, `rd_valid` first high in cycle 2.
- With `rd_ready` held at 1, an N-beat burst delivers one beat per cycle in cycles 2..N+1. `cmd_ready` rises in cycle N+2.
- Under backpressure, at most 2 beats are buffered and issue resumes in the same cycle a pop occurs.
- `rd_ready` may toggle arbitrarily; no beat is lost or duplicated.

## Test plan
- Power-up contents (0=0x90, 1=0xb3, 2=0x23): read `adr`=0, `len`=2, `rd_ready`=1 -> beats 0x90, 0xb3, 0x23 in cycles 2-4; `rd_last` only on 0x23; `cmd_ready` high in cycle 5.
- Wrap: read `adr`=14, `len`=3 -> 0x6e, 0x98, 0x90, 0xb3; `rd_last` on 0xb3.
- Write then read: write 0x5a to `adr` 3, next cycle read `adr`=3, `len`=0 -> single beat 0x5a with `rd_last`=1; `busy` low again 1 cycle after the pop.
- Backpressure: read `adr`=4, `len`=15 with `rd_ready` on a 1-0-0-1 pattern -> all 16 beats in order (0xa7, 0x4f, ...); `fifo_count` never exceeds 2; `rd_data` stable while stalled.
- Reset mid-burst: pull `rst` low during beat 3 of a 16-beat read -> `rd_valid`=0 immediately; after release, `cmd_ready`=1 and no stray beats appear.
- `cmd_valid` in READ/DRAIN -> `cmd_ready`=0, `we` stays 0, and the command is held until IDLE.
